// File: rtl/mem_access.sv
// Load/store unit between the pipeline and the data memory: one access in flight, fixed ACC_LAT response latency.
// Optional build macro MEM_ACCESS_MISALIGN_TRAP_EN: misaligned requests skip memory and report a fault with the address.
module mem_access #(
    parameter int unsigned ACC_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_addr_i,
    input  logic [31:0] in_wdata_i,
    input  logic        in_wen_i,
    input  logic [1:0]  in_size_i,
    input  logic        in_unsigned_i,
    input  logic [4:0]  in_rd_i,
    output logic        mem_en_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic [31:0] mem_rdata_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_data_o,
    output logic [4:0]  out_rd_o,
    output logic        out_misalign_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACC_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wen_q, wen_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    logic        mis_q, mis_d;
`endif

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   is_misaligned = 1'b0;
            2'b01:   is_misaligned = off[0];
            default: is_misaligned = (off != 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   store_strb = 4'b0001 << off;
            2'b01:   store_strb = 4'b0011 << off;
            default: store_strb = 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] load_data(input logic [31:0] rdata, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
        logic [31:0] sh;
        sh = rdata >> {off, 3'b000};
        case (size)
            2'b00:   load_data = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            2'b01:   load_data = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: load_data = rdata;
        endcase
    endfunction

    // State and capture registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wen_q   <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            rd_q    <= 5'd0;
            data_q  <= 32'h0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wen_q   <= wen_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    // Next-state logic; the response word is formed at the end of ACCESS so it stays frozen through RESP
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wen_d   = wen_q;
        size_d  = size_q;
        uns_d   = uns_q;
        rd_d    = rd_q;
        data_d  = data_q;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid_i) begin
                    addr_d  = in_addr_i;
                    wdata_d = in_wdata_i;
                    wen_d   = in_wen_i;
                    size_d  = in_size_i;
                    uns_d   = in_unsigned_i;
                    rd_d    = in_rd_i;
                    data_d  = 32'h0;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                    if (is_misaligned(in_size_i, in_addr_i[1:0])) begin
                        state_d = RESP;
                        data_d  = in_addr_i;
                        mis_d   = 1'b1;
                    end else begin
                        state_d = ACCESS;
                        mis_d   = 1'b0;
                    end
`else
                    state_d = ACCESS;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                data_d = wen_q ? 32'h0 : load_data(mem_rdata_i, size_q, addr_q[1:0], uns_q);
                if (ACC_LAT == 32'd1) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_INIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                if (out_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready_o  = (state_q == IDLE);
    assign mem_en_o    = (state_q == ACCESS);
    assign mem_wr_o    = mem_en_o & wen_q;
    assign mem_wstrb_o = mem_wr_o ? store_strb(size_q, addr_q[1:0]) : 4'b0000;
    assign mem_addr_o  = {addr_q[31:2], 2'b00};
    assign mem_wdata_o = wdata_q << {addr_q[1:0], 3'b000};
    assign out_valid_o = (state_q == RESP);
    assign out_data_o  = data_q;
    assign out_rd_o    = rd_q;
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
    assign out_misalign_o = mis_q;
`else
    assign out_misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: one instance at ACC_LAT=1 and one at ACC_LAT=4 sharing request fields.
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        wen = 1'b0, uns = 1'b0;
    logic [1:0]  size = 2'b10;
    logic [4:0]  rd = 5'd0;

    logic        v1 = 1'b0, ordy1 = 1'b0, rdy1, en1, wr1, ov1, mis1;
    logic [31:0] rdata1 = 32'h0, maddr1, mwdata1, odata1;
    logic [3:0]  strb1;
    logic [4:0]  ord1;

    logic        v4 = 1'b0, ordy4 = 1'b0, rdy4, en4, wr4, ov4, mis4;
    logic [31:0] rdata4 = 32'h0, maddr4, mwdata4, odata4;
    logic [3:0]  strb4;
    logic [4:0]  ord4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_access #(.ACC_LAT(1)) u1 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v1), .in_ready_o(rdy1), .in_addr_i(addr),
        .in_wdata_i(wdata), .in_wen_i(wen), .in_size_i(size), .in_unsigned_i(uns), .in_rd_i(rd),
        .mem_en_o(en1), .mem_wr_o(wr1), .mem_addr_o(maddr1), .mem_wdata_o(mwdata1),
        .mem_wstrb_o(strb1), .mem_rdata_i(rdata1), .out_valid_o(ov1), .out_ready_i(ordy1),
        .out_data_o(odata1), .out_rd_o(ord1), .out_misalign_o(mis1));

    mem_access #(.ACC_LAT(4)) u4 (
        .clk_i(clk), .rst_i(rst), .in_valid_i(v4), .in_ready_o(rdy4), .in_addr_i(addr),
        .in_wdata_i(wdata), .in_wen_i(wen), .in_size_i(size), .in_unsigned_i(uns), .in_rd_i(rd),
        .mem_en_o(en4), .mem_wr_o(wr4), .mem_addr_o(maddr4), .mem_wdata_o(mwdata4),
        .mem_wstrb_o(strb4), .mem_rdata_i(rdata4), .out_valid_o(ov4), .out_ready_i(ordy4),
        .out_data_o(odata4), .out_rd_o(ord4), .out_misalign_o(mis4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] a, input logic [31:0] d, input logic w,
                           input logic [1:0] s, input logic u, input logic [4:0] r);
        addr = a; wdata = d; wen = w; size = s; uns = u; rd = r;
    endtask

    // Present a request to the ACC_LAT=1 instance for one cycle; returns in the cycle after accept
    task automatic accept1();
        v1 = 1'b1;
        tick();
        v1 = 1'b0;
    endtask

    task automatic handshake1();
        ordy1 = 1'b1;
        tick();
        ordy1 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_vec++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", rdy1); end
        n_vec++; if ({ov1, mis1, en1, wr1} !== 4'b0000) begin n_err++; $display("FAIL reset_flags got %b want 0000", {ov1, mis1, en1, wr1}); end
        n_vec++; if ({odata1, ord1} !== 37'h0) begin n_err++; $display("FAIL reset_data got %h/%h want 0/0", odata1, ord1); end
        n_vec++; if (strb1 !== 4'b0000) begin n_err++; $display("FAIL reset_strb got %b want 0000", strb1); end
    endtask

    task automatic test_load_word();
        set_req(32'h80000004, 32'h0, 1'b0, 2'b10, 1'b0, 5'd5);
        accept1();
        rdata1 = 32'hDEADBEEF;
        n_vec++; if ({en1, wr1, rdy1} !== 3'b100) begin n_err++; $display("FAIL lw_access_strobes got %b want 100", {en1, wr1, rdy1}); end
        n_vec++; if (maddr1 !== 32'h80000004) begin n_err++; $display("FAIL lw_mem_addr got %h want 80000004", maddr1); end
        n_vec++; if (ov1 !== 1'b0) begin n_err++; $display("FAIL lw_valid_early got %b want 0", ov1); end
        tick();
        rdata1 = 32'h0;
        n_vec++; if ({ov1, en1} !== 2'b10) begin n_err++; $display("FAIL lw_valid got %b want 10", {ov1, en1}); end
        n_vec++; if (odata1 !== 32'hDEADBEEF) begin n_err++; $display("FAIL lw_data got %h want deadbeef", odata1); end
        n_vec++; if (ord1 !== 5'd5) begin n_err++; $display("FAIL lw_rd got %0d want 5", ord1); end
        handshake1();
        n_vec++; if ({rdy1, ov1} !== 2'b10) begin n_err++; $display("FAIL lw_after_hs got %b want 10", {rdy1, ov1}); end
    endtask

    task automatic test_load_sub();
        logic [31:0] exp_tab [3] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8012};
        logic [31:0] addr_tab[3] = '{32'h80000003, 32'h80000003, 32'h80000002};
        logic [1:0]  size_tab[3] = '{2'b00, 2'b00, 2'b01};
        logic        uns_tab [3] = '{1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            set_req(addr_tab[i], 32'h0, 1'b0, size_tab[i], uns_tab[i], 5'(i + 10));
            accept1();
            rdata1 = 32'h80123456;
            n_vec++; if (maddr1 !== 32'h80000000) begin n_err++; $display("FAIL lsub%0d_mem_addr got %h want 80000000", i, maddr1); end
            tick();
            rdata1 = 32'h0;
            n_vec++; if (odata1 !== exp_tab[i]) begin n_err++; $display("FAIL lsub%0d_data got %h want %h", i, odata1, exp_tab[i]); end
            n_vec++; if (mis1 !== 1'b0) begin n_err++; $display("FAIL lsub%0d_misalign got %b want 0", i, mis1); end
            handshake1();
        end
    endtask

    task automatic test_store();
        logic [31:0] a_tab[2] = '{32'h80000002, 32'h80000001};
        logic [31:0] d_tab[2] = '{32'h0000ABCD, 32'h12345678};
        logic [1:0]  s_tab[2] = '{2'b01, 2'b00};
        logic [31:0] w_tab[2] = '{32'hABCD0000, 32'h34567800};
        logic [3:0]  b_tab[2] = '{4'b1100, 4'b0010};
        for (int i = 0; i < 2; i++) begin
            set_req(a_tab[i], d_tab[i], 1'b1, s_tab[i], 1'b0, 5'd3);
            accept1();
            rdata1 = 32'hFFFFFFFF;
            n_vec++; if ({en1, wr1} !== 2'b11) begin n_err++; $display("FAIL st%0d_strobes got %b want 11", i, {en1, wr1}); end
            n_vec++; if (strb1 !== b_tab[i]) begin n_err++; $display("FAIL st%0d_wstrb got %b want %b", i, strb1, b_tab[i]); end
            n_vec++; if (mwdata1 !== w_tab[i]) begin n_err++; $display("FAIL st%0d_wdata got %h want %h", i, mwdata1, w_tab[i]); end
            tick();
            rdata1 = 32'h0;
            n_vec++; if ({ov1, en1, wr1, strb1} !== 7'b1000000) begin n_err++; $display("FAIL st%0d_resp_strobes got %b want 1000000", i, {ov1, en1, wr1, strb1}); end
            n_vec++; if (odata1 !== 32'h0) begin n_err++; $display("FAIL st%0d_data got %h want 0", i, odata1); end
            handshake1();
        end
    endtask

    task automatic test_misalign();
        set_req(32'h80000001, 32'h0, 1'b0, 2'b10, 1'b0, 5'd7);
        accept1();
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        n_vec++; if ({en1, ov1, mis1} !== 3'b011) begin n_err++; $display("FAIL trap_flags got %b want 011", {en1, ov1, mis1}); end
        n_vec++; if (odata1 !== 32'h80000001) begin n_err++; $display("FAIL trap_data got %h want 80000001", odata1); end
        n_vec++; if (ord1 !== 5'd7) begin n_err++; $display("FAIL trap_rd got %0d want 7", ord1); end
`else
        rdata1 = 32'h11223344;
        n_vec++; if ({en1, maddr1} !== {1'b1, 32'h80000000}) begin n_err++; $display("FAIL mis_access got %b/%h want 1/80000000", en1, maddr1); end
        tick();
        rdata1 = 32'h0;
        n_vec++; if ({ov1, mis1} !== 2'b10) begin n_err++; $display("FAIL mis_flags got %b want 10", {ov1, mis1}); end
        n_vec++; if (odata1 !== 32'h11223344) begin n_err++; $display("FAIL mis_data got %h want 11223344", odata1); end
`endif
        handshake1();
        n_vec++; if (rdy1 !== 1'b1) begin n_err++; $display("FAIL mis_idle got %b want 1", rdy1); end
    endtask

    task automatic test_latency4();
        int pulses = 0;
        set_req(32'h80000010, 32'h0, 1'b0, 2'b10, 1'b0, 5'd21);
        v4 = 1'b1;
        tick();
        v4 = 1'b0;
        rdata4 = 32'hCAFEF00D;
        // cycles N+1 .. N+4: single mem_en pulse, no response yet
        for (int c = 1; c <= 4; c++) begin
            if (en4 === 1'b1) pulses++;
            n_vec++; if ({ov4, rdy4} !== 2'b00) begin n_err++; $display("FAIL lat4_c%0d got valid/ready %b want 00", c, {ov4, rdy4}); end
            tick();
            rdata4 = 32'h0;
        end
        n_vec++; if (pulses !== 1) begin n_err++; $display("FAIL lat4_pulses got %0d want 1", pulses); end
        for (int c = 0; c < 4; c++) begin
            n_vec++; if ({ov4, rdy4, en4} !== 3'b100) begin n_err++; $display("FAIL lat4_hold%0d got %b want 100", c, {ov4, rdy4, en4}); end
            n_vec++; if ({odata4, ord4} !== {32'hCAFEF00D, 5'd21}) begin n_err++; $display("FAIL lat4_stable%0d got %h/%0d want cafef00d/21", c, odata4, ord4); end
            if (c < 3) tick();
        end
        // handshake cycle with a request already waiting: it must not be taken yet
        ordy4 = 1'b1;
        v4 = 1'b1;
        tick();
        ordy4 = 1'b0;
        n_vec++; if ({rdy4, ov4, en4} !== 3'b100) begin n_err++; $display("FAIL b2b_idle got %b want 100", {rdy4, ov4, en4}); end
        tick();
        v4 = 1'b0;
        n_vec++; if (en4 !== 1'b1) begin n_err++; $display("FAIL b2b_accept got %b want 1", en4); end
    endtask

    task automatic test_reset_mid();
        // instance 4 is in ACCESS here
        rst = 1'b1;
        #1;
        n_vec++; if (en4 !== 1'b1) begin n_err++; $display("FAIL rst_access_en got %b want 1", en4); end
        tick();
        rst = 1'b0;
        n_vec++; if ({rdy4, en4, ov4} !== 3'b100) begin n_err++; $display("FAIL rst_access_after got %b want 100", {rdy4, en4, ov4}); end
        set_req(32'h80000020, 32'h0, 1'b0, 2'b10, 1'b0, 5'd9);
        v4 = 1'b1;
        tick();
        v4 = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_vec++; if ({rdy4, ov4} !== 2'b10) begin n_err++; $display("FAIL rst_wait_after got %b want 10", {rdy4, ov4}); end
        for (int c = 0; c < 6; c++) begin
            n_vec++; if (ov4 !== 1'b0) begin n_err++; $display("FAIL rst_wait_no_resp%0d got %b want 0", c, ov4); end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_load_word();
        test_load_sub();
        test_store();
        test_misalign();
        test_latency4();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
